// File: rtl/sun_pll_pkg.sv
// Shared types and helpers for the SUN PLL feedback divider slice.
package sun_pll_pkg;

  typedef enum logic [1:0] {
    S_KICK,
    S_ARM,
    S_TRACK
  } state_e;

  localparam int unsigned DIVN_MIN = 2;

  function automatic int unsigned clamp_divn(input int unsigned n);
    return (n < DIVN_MIN) ? DIVN_MIN : n;
  endfunction

endpackage

// File: rtl/sun_pll_sync.sv
// Multi-flop synchroniser for an asynchronous reference clock plus a one-cycle rising-edge pulse.
module sun_pll_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ck,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/sun_pll_divn_prog.sv
// Programmable CK divider producing CK_FB, with power-up KICK pulse and
// reference-period based digital lock detect, all in the CK domain.
module sun_pll_divn_prog
  import sun_pll_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16,
  parameter int KICK_CYCLES = 64
) (
  input  logic             CK,
  input  logic             PWRUP_1V8,
  input  logic [WIDTH-1:0] DIV_N,
  input  logic             CK_REF,
  output logic             CK_FB,
  output logic             KICK,
  output logic             LOCK
);

  localparam int PER_W  = WIDTH + 1;
  localparam int CMP_W  = WIDTH + 2;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int KICK_W = $clog2(KICK_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_MAX = '1;

  function automatic logic [PER_W-1:0] per_inc(input logic [PER_W-1:0] p);
    return (p == PER_MAX) ? PER_MAX : p + 1'b1;
  endfunction

  function automatic logic [GOOD_W-1:0] good_inc(input logic [GOOD_W-1:0] g);
    return (g >= GOOD_W'(LOCK_CNT)) ? GOOD_W'(LOCK_CNT) : g + 1'b1;
  endfunction

  // A saturated period means the reference is missing or far too slow: never good.
  function automatic logic in_tol(input logic [PER_W-1:0] p, input logic [WIDTH-1:0] n);
    logic [CMP_W-1:0] a, b, diff;
    a    = CMP_W'(p);
    b    = CMP_W'(n);
    diff = (a >= b) ? a - b : b - a;
    return (p != PER_MAX) && (diff <= CMP_W'(LOCK_TOL));
  endfunction

  logic [WIDTH-1:0]  cnt_q, cnt_d, n_act_q, n_act_d, n_req;
  logic              fb_q, fb_d;
  logic [KICK_W-1:0] kick_cnt_q, kick_cnt_d;
  logic              kick_q, kick_d, lock_q, lock_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [GOOD_W-1:0] good_q, good_d;
  state_e            state_q, state_d;
  logic              ref_rise, terminal, n_chg;

  sun_pll_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .ck    (CK),
    .rst_n (PWRUP_1V8),
    .d     (CK_REF),
    .rise  (ref_rise)
  );

  assign n_req = WIDTH'(clamp_divn(32'(DIV_N)));

  // Ratio is only adopted at the terminal count, so a period is never cut or stretched.
  always_comb begin
    terminal = (cnt_q == '0);
    n_act_d  = terminal ? n_req : n_act_q;
    cnt_d    = terminal ? n_req - 1'b1 : cnt_q - 1'b1;
    fb_d     = (cnt_d >= n_act_d - (n_act_d >> 1));
    n_chg    = terminal && (n_req != n_act_q);
    per_d    = ref_rise ? PER_W'(1) : per_inc(per_q);
  end

  always_comb begin
    state_d    = state_q;
    kick_cnt_d = kick_cnt_q;
    kick_d     = 1'b0;
    good_d     = good_q;
    lock_d     = 1'b0;
    case (state_q)
      S_KICK: begin
        good_d = '0;
        if (kick_cnt_q == KICK_W'(KICK_CYCLES)) begin
          state_d = S_ARM;
        end else begin
          kick_d     = 1'b1;
          kick_cnt_d = kick_cnt_q + 1'b1;
        end
      end
      S_ARM: begin
        good_d = '0;
        if (!n_chg && ref_rise) state_d = S_TRACK;
      end
      S_TRACK: begin
        // A ratio change outranks a coincident reference edge.
        if (n_chg) begin
          good_d  = '0;
          state_d = S_ARM;
        end else if (ref_rise) begin
          good_d = in_tol(per_q, n_act_q) ? good_inc(good_q) : '0;
        end
        lock_d = (good_d == GOOD_W'(LOCK_CNT));
      end
      default: begin
        state_d = S_KICK;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      cnt_q      <= '0;
      n_act_q    <= WIDTH'(DIVN_MIN);
      fb_q       <= 1'b0;
      kick_cnt_q <= '0;
      kick_q     <= 1'b0;
      lock_q     <= 1'b0;
      per_q      <= '0;
      good_q     <= '0;
      state_q    <= S_KICK;
    end else begin
      cnt_q      <= cnt_d;
      n_act_q    <= n_act_d;
      fb_q       <= fb_d;
      kick_cnt_q <= kick_cnt_d;
      kick_q     <= kick_d;
      lock_q     <= lock_d;
      per_q      <= per_d;
      good_q     <= good_d;
      state_q    <= state_d;
    end
  end

  assign CK_FB = fb_q;
  assign KICK  = kick_q;
  assign LOCK  = lock_q;

endmodule
